// File: rtl/brush_raster.sv
// brush_raster: stroke-drawing engine between the SPI command decoder and the
// pixel store. Commands are queued in a small FIFO and then turned into
// single-pixel writes, one pixel per accepted write.
//   STAMP : a square brush of half-width cmd_radius around (cmd_x, cmd_y),
//           clipped to the frame; cmd_erase paints colour 0.
//   CLEAR : fills the whole frame with cmd_color.
//   NOP   : consumed without any writes.
// Ports:
//   clk, reset                 pixel clock, asynchronous active-high reset
//   cmd_valid / cmd_ready      command handshake (cmd_ready = FIFO not full)
//   cmd_op/x/y/radius/color/erase  command payload
//   wr_en / wr_ready           pixel write handshake (write lands on wr_en && wr_ready)
//   wr_x, wr_y, wr_color       registered write address and colour
//   busy                       FIFO non-empty or engine active
module brush_raster #(
  parameter int unsigned XW    = 8,
  parameter int unsigned YW    = 8,
  parameter int unsigned XMAX  = 159,
  parameter int unsigned YMAX  = 119,
  parameter int unsigned CW    = 3,
  parameter int unsigned RW    = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [RW-1:0] cmd_radius,
  input  logic [CW-1:0] cmd_color,
  input  logic          cmd_erase,
  output logic          wr_en,
  input  logic          wr_ready,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [CW-1:0] wr_color,
  output logic          busy
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned XW1  = XW + 1;
  localparam int unsigned YW1  = YW + 1;

  localparam logic [1:0]    OP_STAMP = 2'b00;
  localparam logic [1:0]    OP_CLEAR = 2'b01;
  localparam logic [XW:0]   XMAX_W   = XW1'(XMAX);
  localparam logic [YW:0]   YMAX_W   = YW1'(YMAX);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef struct packed {
    logic [1:0]    op;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [RW-1:0] r;
    logic [CW-1:0] color;
    logic          erase;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_CLEAR
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  cmd_t            cmd_q, cmd_d;
  logic [XW-1:0]   x0_q, x0_d;
  logic [XW-1:0]   x1_q, x1_d;
  logic [YW-1:0]   y1_q, y1_d;
  logic            wr_en_q, wr_en_d;
  logic [XW-1:0]   wr_x_q, wr_x_d;
  logic [YW-1:0]   wr_y_q, wr_y_d;
  logic [CW-1:0]   wr_color_q, wr_color_d;

  cmd_t            fifo_mem [DEPTH];
  cmd_t            cmd_in_c;
  logic            full_c;
  logic            push_c;
  logic            pop_c;

  // Clipped stamp bounds, evaluated one bit wider so x-r / x+r never wrap
  logic [XW:0]     xs_lo_c, xs_hi_c;
  logic [YW:0]     ys_lo_c, ys_hi_c;
  logic [XW-1:0]   x0_c, x1_c;
  logic [YW-1:0]   y0_c, y1_c;
  logic            off_frame_c;
  logic            last_col_c;
  logic            last_row_c;

  assign cmd_in_c = '{op: cmd_op, x: cmd_x, y: cmd_y, r: cmd_radius,
                      color: cmd_color, erase: cmd_erase};

  assign full_c = (cnt_q == FULL_CNT);
  assign push_c = cmd_valid && !full_c;
  assign pop_c  = (state_q == S_IDLE) && (cnt_q != '0);

  assign xs_lo_c = {1'b0, cmd_q.x} - XW1'(cmd_q.r);
  assign xs_hi_c = {1'b0, cmd_q.x} + XW1'(cmd_q.r);
  assign ys_lo_c = {1'b0, cmd_q.y} - YW1'(cmd_q.r);
  assign ys_hi_c = {1'b0, cmd_q.y} + YW1'(cmd_q.r);

  // A set MSB on the subtraction means x < r, i.e. the brush hangs off the left/top edge
  assign x0_c = xs_lo_c[XW] ? '0 : xs_lo_c[XW-1:0];
  assign y0_c = ys_lo_c[YW] ? '0 : ys_lo_c[YW-1:0];
  assign x1_c = (xs_hi_c > XMAX_W) ? XW'(XMAX) : xs_hi_c[XW-1:0];
  assign y1_c = (ys_hi_c > YMAX_W) ? YW'(YMAX) : ys_hi_c[YW-1:0];

  assign off_frame_c = (cmd_q.x > XW'(XMAX)) || (cmd_q.y > YW'(YMAX));

  assign last_col_c = (wr_x_q == x1_q);
  assign last_row_c = (wr_y_q == y1_q);

  // Command FIFO storage; occupancy and pointers live with the rest of the state
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wptr_q] <= cmd_in_c;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cmd_q      <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_color_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cmd_q      <= cmd_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_color_q <= wr_color_d;
    end
  end

  // Next-state: FIFO bookkeeping, command sequencing and raster stepping
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cmd_d      = cmd_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    wr_en_d    = wr_en_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_color_d = wr_color_q;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own
    if (push_c) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop_c) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop_c) begin
          cmd_d   = fifo_mem[rptr_q];
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (cmd_q.op == OP_CLEAR) begin
          x0_d       = '0;
          x1_d       = XW'(XMAX);
          y1_d       = YW'(YMAX);
          wr_x_d     = '0;
          wr_y_d     = '0;
          wr_color_d = cmd_q.color;
          wr_en_d    = 1'b1;
          state_d    = S_CLEAR;
        end else if ((cmd_q.op == OP_STAMP) && !off_frame_c) begin
          x0_d       = x0_c;
          x1_d       = x1_c;
          y1_d       = y1_c;
          wr_x_d     = x0_c;
          wr_y_d     = y0_c;
          wr_color_d = cmd_q.erase ? '0 : cmd_q.color;
          wr_en_d    = 1'b1;
          state_d    = S_DRAW;
        end else begin
          // NOP or a stamp centred outside the frame: nothing to draw
          state_d = S_IDLE;
        end
      end

      S_DRAW, S_CLEAR: begin
        // Hold the current pixel until the store takes it
        if (wr_ready) begin
          if (last_col_c) begin
            if (last_row_c) begin
              wr_en_d = 1'b0;
              state_d = S_IDLE;
            end else begin
              wr_x_d = x0_q;
              wr_y_d = wr_y_q + YW'(1);
            end
          end else begin
            wr_x_d = wr_x_q + XW'(1);
          end
        end
      end

      default: begin
        wr_en_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = !full_c;
  assign busy      = (state_q != S_IDLE) || (cnt_q != '0);
  assign wr_en     = wr_en_q;
  assign wr_x      = wr_x_q;
  assign wr_y      = wr_y_q;
  assign wr_color  = wr_color_q;

endmodule

// File: tb/tb_brush_raster.sv
// Self-checking bench for brush_raster: directed scenarios plus a randomized
// phase, with a pixel-list reference model feeding a scoreboard queue.
module tb_brush_raster;

  localparam int XMAX = 159;
  localparam int YMAX = 119;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_x;
  logic [7:0] cmd_y;
  logic [2:0] cmd_radius;
  logic [2:0] cmd_color;
  logic       cmd_erase;
  logic       wr_en;
  logic       wr_ready;
  logic [7:0] wr_x;
  logic [7:0] wr_y;
  logic [2:0] wr_color;
  logic       busy;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t exp_q[$];

  int n_checks    = 0;
  int n_pass      = 0;
  int nwrites     = 0;
  int cyc         = 0;
  int last_wr_cyc = 0;
  int rdy_mode    = 0;   // 0: always ready, 1: random, 2: held low
  bit prev_stall  = 1'b0;
  int hold_v      = 0;

  brush_raster dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_radius (cmd_radius),
    .cmd_color  (cmd_color),
    .cmd_erase  (cmd_erase),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_color   (wr_color),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel-store readiness
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = ($urandom_range(0, 3) != 0);
      default: wr_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: list every pixel a command must produce, in raster order
  function automatic void model_push(int op, int x, int y, int r, int c, int e);
    int xl, xh, yl, yh;
    if (op == 1) begin
      for (int yy = 0; yy <= YMAX; yy++)
        for (int xx = 0; xx <= XMAX; xx++)
          exp_q.push_back('{xx, yy, c});
    end else if (op == 0 && x <= XMAX && y <= YMAX) begin
      xl = (x - r < 0) ? 0 : x - r;
      xh = (x + r > XMAX) ? XMAX : x + r;
      yl = (y - r < 0) ? 0 : y - r;
      yh = (y + r > YMAX) ? YMAX : y + r;
      for (int yy = yl; yy <= yh; yy++)
        for (int xx = xl; xx <= xh; xx++)
          exp_q.push_back('{xx, yy, (e != 0) ? 0 : c});
    end
  endfunction

  // Monitor: handshakes are decided at the next rising edge, sampled here mid-cycle
  always @(negedge clk) begin
    pix_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready)
        model_push(int'(cmd_op), int'(cmd_x), int'(cmd_y), int'(cmd_radius),
                   int'(cmd_color), int'(cmd_erase));
      if (prev_stall)
        chk("stall_hold", int'({wr_en, wr_x, wr_y, wr_color}), hold_v);
      if (wr_en && wr_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL write: got unexpected (%0d,%0d,c%0d), expected none", wr_x, wr_y, wr_color);
        end else begin
          e = exp_q.pop_front();
          if (e.x == int'(wr_x) && e.y == int'(wr_y) && e.c == int'(wr_color)) n_pass++;
          else $display("FAIL write #%0d: got (%0d,%0d,c%0d), expected (%0d,%0d,c%0d)",
                        nwrites, wr_x, wr_y, wr_color, e.x, e.y, e.c);
        end
        nwrites++;
        last_wr_cyc = cyc;
      end
      prev_stall = wr_en && !wr_ready;
      hold_v     = int'({1'b1, wr_x, wr_y, wr_color});
    end
  end

  // Starts and ends just after a rising edge
  task automatic send_cmd(input int op, input int x, input int y, input int r,
                          input int c, input int e, input int budget,
                          output bit acc, output int acc_cyc);
    cmd_op     = 2'(op);
    cmd_x      = 8'(x);
    cmd_y      = 8'(y);
    cmd_radius = 3'(r);
    cmd_color  = 3'(c);
    cmd_erase  = 1'(e);
    cmd_valid  = 1'b1;
    acc        = 1'b0;
    acc_cyc    = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc     = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int idle_cyc);
    bit done = 1'b0;
    idle_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle_cyc = cyc;
        done     = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int  acc_c, idle_c, first_c, base;
    bit  acc;
    int  op, x, y;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
    cmd_radius = '0; cmd_color = '0; cmd_erase = 1'b0;
    #3;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_x", int'(wr_x), 0);
    chk("rst_wr_y", int'(wr_y), 0);
    chk("rst_wr_color", int'(wr_color), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic stamp: latency, 9 writes, busy falls right after the last write
    base = nwrites;
    send_cmd(0, 10, 20, 1, 5, 0, 4, acc, acc_c);
    chk("t1_accept", int'(acc), 1);
    first_c = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_en) begin
        first_c = cyc;
        break;
      end
    end
    chk("t1_latency", first_c - acc_c, 3);
    wait_idle(200, idle_c);
    chk("t1_busy_fall", idle_c, last_wr_cyc + 1);
    chk("t1_count", nwrites - base, 9);
    chk("t1_drained", exp_q.size(), 0);

    // Clipping at the top-left corner
    base = nwrites;
    send_cmd(0, 0, 0, 2, 3, 0, 4, acc, acc_c);
    wait_idle(200, idle_c);
    chk("clip_tl_count", nwrites - base, 9);
    chk("clip_tl_drained", exp_q.size(), 0);

    // Clipping at the bottom-right corner
    base = nwrites;
    send_cmd(0, XMAX, YMAX, 1, 6, 0, 4, acc, acc_c);
    wait_idle(200, idle_c);
    chk("clip_br_count", nwrites - base, 4);
    chk("clip_br_drained", exp_q.size(), 0);

    // Centre off the frame: dropped, busy gone once LOAD is over
    base = nwrites;
    send_cmd(0, 200, 10, 1, 6, 0, 4, acc, acc_c);
    wait_idle(50, idle_c);
    chk("offframe_busy_fall", idle_c - acc_c, 3);
    chk("offframe_count", nwrites - base, 0);

    // Back-pressure after the 4th write of an erase stamp
    base = nwrites;
    send_cmd(0, 50, 50, 1, 3, 1, 4, acc, acc_c);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (nwrites >= base + 4) break;
    end
    rdy_mode = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_wr_en", int'(wr_en), 1);
      chk("bp_wr_x", int'(wr_x), 50);
      chk("bp_wr_y", int'(wr_y), 50);
      chk("bp_wr_color", int'(wr_color), 0);
    end
    rdy_mode = 0;
    @(posedge clk); #1;
    wait_idle(200, idle_c);
    chk("bp_count", nwrites - base, 9);
    chk("bp_drained", exp_q.size(), 0);

    // FIFO full: engine stalled, 1 in the engine plus DEPTH queued
    rdy_mode = 2;
    @(posedge clk); #1;
    base = nwrites;
    send_cmd(0, 30, 30, 0, 1, 0, 3, acc, acc_c); chk("full_acc1", int'(acc), 1);
    send_cmd(0, 40, 30, 1, 2, 0, 3, acc, acc_c); chk("full_acc2", int'(acc), 1);
    send_cmd(0, 60, 30, 0, 3, 0, 3, acc, acc_c); chk("full_acc3", int'(acc), 1);
    send_cmd(0, 70, 30, 1, 4, 0, 3, acc, acc_c); chk("full_acc4", int'(acc), 1);
    send_cmd(0, 90, 30, 2, 6, 0, 3, acc, acc_c); chk("full_acc5", int'(acc), 1);
    chk("full_ready_low", int'(cmd_ready), 0);
    send_cmd(0, 100, 100, 1, 7, 0, 6, acc, acc_c);
    chk("full_sixth_held", int'(acc), 0);
    chk("full_no_writes", nwrites - base, 0);
    rdy_mode = 0;
    wait_idle(500, idle_c);
    chk("full_count", nwrites - base, 1 + 9 + 1 + 9 + 25);
    chk("full_drained", exp_q.size(), 0);

    // Full-screen clear with a stamp queued behind it
    base = nwrites;
    send_cmd(1, 7, 7, 7, 2, 1, 4, acc, acc_c);
    send_cmd(0, 5, 5, 0, 4, 0, 4, acc, acc_c);
    wait_idle(25000, idle_c);
    chk("clear_count", nwrites - base, (XMAX + 1) * (YMAX + 1) + 1);
    chk("clear_drained", exp_q.size(), 0);

    // Reset mid-stroke with another command queued
    base = nwrites;
    send_cmd(0, 80, 60, 7, 3, 0, 4, acc, acc_c);
    send_cmd(0, 20, 20, 2, 1, 0, 4, acc, acc_c);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (nwrites >= base + 20) break;
    end
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    base = nwrites;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_stale", nwrites - base, 0);
    chk("midrst_idle", int'(busy), 0);

    // Randomized commands under random back-pressure
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : 0;
      x  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(XMAX + 1, 255)) : int'($urandom_range(0, XMAX));
      y  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(YMAX + 1, 255)) : int'($urandom_range(0, YMAX));
      send_cmd(op, x, y, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 1)), 3000, acc, acc_c);
      chk("rand_accept", int'(acc), 1);
    end
    wait_idle(20000, idle_c);
    chk("rand_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/brush_raster.md
Name: brush_raster

Overview:
- Parametrised stroke-drawing engine between the SPI command decoder and the pixel store.
- Queues drawing commands in a small FIFO, then rasterises each one into single-pixel writes to the frame store:
  - a square brush stamp of programmable radius, clipped to the frame, or
  - a full-screen fill.
- Replaces the fixed one-pixel brush path with variable brush size, erase, clear, and write back-pressure.

Parameters:
XW  8  x coordinate width
YW  8  y coordinate width
XMAX  159  last valid column (XMAX < 2^XW)
YMAX  119  last valid row (YMAX < 2^YW)
CW  3  colour code width
RW  3  brush radius width; radius 0..2^RW-1
DEPTH  4  command FIFO depth, power of two, >= 2

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high; clears all state
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; equals !full
cmd_op  in  2  00 STAMP, 01 CLEAR, 10/11 NOP
cmd_x  in  XW  stamp centre column
cmd_y  in  YW  stamp centre row
cmd_radius  in  RW  stamp half-width
cmd_color  in  CW  draw / fill colour
cmd_erase  in  1  STAMP writes colour 0 instead of cmd_color
wr_en  out  1  pixel write request
wr_ready  in  1  pixel store accepts write this cycle
wr_x  out  XW  write column
wr_y  out  YW  write row
wr_color  out  CW  write colour
busy  out  1  FIFO non-empty or engine not IDLE

Behaviour:
- Reset (async, active-high):
  - FIFO emptied, state IDLE.
  - wr_en = 0; wr_x, wr_y, wr_color = 0; busy = 0; cmd_ready = 1.
  - Any in-progress stroke is abandoned immediately; no partial resume.
- FIFO:
  - Push on cmd_valid && cmd_ready. cmd_ready depends only on occupancy (no fall-through when full).
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, DRAW, CLEAR.
- IDLE:
  - If FIFO is non-empty, pop the head into command registers and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - NOP → IDLE.
  - CLEAR → init cx = 0, cy = 0 → CLEAR state.
  - STAMP with x > XMAX or y > YMAX → dropped, no writes, → IDLE.
  - STAMP otherwise:
    - x0 = max(x-r, 0), x1 = min(x+r, XMAX); y0, y1 likewise.
    - Computed in XW+1 / YW+1 bits so that no underflow or overflow wraps.
    - cx = x0, cy = y0 → DRAW.
- DRAW:
  - wr_en = 1; wr_x = cx; wr_y = cy; wr_color = erase ? 0 : color.
  - Advances only on wr_ready. All wr_* outputs are held stable while wr_ready = 0.
  - Raster order: if cx == x1 then cx = x0, cy++; else cx++.
  - The write accepted at (x1, y1) → IDLE.
  - Write count = (x1-x0+1)·(y1-y0+1); radius 0 gives exactly 1 write.
- CLEAR:
  - Same stepping over 0..XMAX × 0..YMAX.
  - wr_color = cmd_color; cmd_erase is ignored.
  - (XMAX+1)(YMAX+1) writes, then IDLE.
- Outputs: wr_* are registered from state (no combinational path from cmd_* to wr_*).
- Latency: command accepted at cycle N into an empty FIFO with the engine IDLE:
  - pop at N+1, LOAD at N+2, first wr_en at N+3.
  - Back-to-back commands: 2 idle cycles (IDLE, LOAD) between the last write of one and the first write of the next.
- Every pixel is written exactly once per command; no duplicates or skips under any wr_ready pattern.
- busy deasserts the cycle after the final accepted write, provided the FIFO is empty.

Test Plan:
- Defaults, wr_ready = 1: STAMP (10,20) r=1 colour 5 → 9 writes (9,19),(10,19),(11,19),(9,20)…(11,21), all colour 5; first wr_en 3 cycles after acceptance; busy then falls.
- Clipping:
  - STAMP (0,0) r=2 → 9 writes covering x,y ∈ 0..2.
  - STAMP (159,119) r=1 → 4 writes (158..159, 118..119).
  - STAMP x=200 → zero writes, busy drops after LOAD.
- Back-pressure: STAMP (50,50) r=1 erase=1; wr_ready low 5 cycles after the 4th write → wr_x/wr_y/wr_color frozen at (50,50,0); 9 total writes, no duplicates.
- FIFO full: wr_ready held 0, push 6 STAMPs → 1 in engine + 4 queued, cmd_ready = 0 after the 5th acceptance, 6th held off; release wr_ready → all 5 drawn in order.
- CLEAR colour 2 → exactly 19200 writes, final write at (159,119), every write colour 2; a STAMP queued behind it starts only afterwards.
- Reset asserted mid-DRAW → wr_en = 0 and busy = 0 without waiting for a clock edge, cmd_ready = 1; after release no stale writes occur.
